// File: rtl/event_encoder_8_to_3.sv
// Event encoder: collects up to eight request bits into a pending register and
// presents them one at a time as a 3-bit binary code, lowest or highest index
// first, with a valid/ready handshake towards the consumer.
//
// Handshake: Valid=1 means Code_Out names a pending event. A transfer happens on
// any rising edge where Valid=1 and Ready=1. Once Valid is high, Code_Out and
// Valid stay unchanged until that transfer. Ready has no effect while Valid=0.
module event_encoder_8_to_3 #(
    parameter int LOW_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Enable,
    input  logic [7:0] Req_In,
    input  logic       Ready,
    output logic [2:0] Code_Out,
    output logic       Valid,
    output logic [7:0] Pending,
    output logic       Overflow,
    output logic       o_dbg_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_code;
    logic [2:0] w_code_next;
    logic [7:0] r_pend;
    logic       r_ovf;

    logic       w_handshake;
    logic [7:0] w_clear;
    logic [7:0] w_req;
    logic [7:0] w_remain;
    logic [7:0] w_pend_next;
    logic       w_ovf_next;

    // Priority encoder; the scan order makes the winning index the lowest
    // (LOW_FIRST != 0) or the highest set bit.
    function automatic logic [2:0] f_prio(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (LOW_FIRST != 0) begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    assign w_handshake = (r_state == ST_SEND) && Ready;
    assign w_clear     = w_handshake ? (8'b1 << r_code) : 8'h00;
    assign w_req       = Enable ? Req_In : 8'h00;
    // Events still waiting after this cycle's transfer, before new arrivals.
    assign w_remain    = r_pend & ~w_clear;
    // A new set on a bit being cleared this cycle wins and is not an overflow.
    assign w_pend_next = w_remain | w_req;
    assign w_ovf_next  = |(w_req & w_remain);

    // Next-state and next-code selection for the IDLE/SEND controller.
    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        case (r_state)
            ST_IDLE: begin
                if (|r_pend) begin
                    w_code_next  = f_prio(r_pend);
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_handshake) begin
                    if (|w_remain) begin
                        w_code_next = f_prio(w_remain);
                    end else begin
                        // Arrivals from this cycle are picked up from IDLE.
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pending vector, presented code and overflow pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 8'h00;
            r_code <= 3'd0;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            r_code <= w_code_next;
            r_ovf  <= w_ovf_next;
        end
    end

    assign Code_Out    = r_code;
    assign Valid       = (r_state == ST_SEND);
    assign Pending     = r_pend;
    assign Overflow    = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: doc/event_encoder_8_to_3.md
EVENT_ENCODER_8_TO_3 -- requirements
Module: event_encoder_8_to_3

Interface
REQ-001 SHALL have parameter LOW_FIRST, default 1; 1 = lowest pending index is encoded first, 0 = highest pending index is encoded first.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port Enable  input  1  1 = Req_In accepted; 0 = Req_In ignored.
REQ-005 SHALL have port Req_In  input  8  event request bits; any number may be 1 in one cycle.
REQ-006 SHALL have port Ready  input  1  consumer accepts Code_Out this cycle.
REQ-007 SHALL have port Code_Out  output  3  binary index of the event being presented.
REQ-008 SHALL have port Valid  output  1  Code_Out holds a pending event.
REQ-009 SHALL have port Pending  output  8  registered pending-event vector.
REQ-010 SHALL have port Overflow  output  1  one-cycle pulse when a request hits an already-pending bit.

Function
REQ-011 SHALL keep an 8-bit pending register P, visible on Pending.
REQ-012 SHALL accept a handshake on a rising edge where Valid=1 and Ready=1; clear mask C = onehot(Code_Out) on handshake, else 0.
REQ-013 SHALL update P_next = (P & ~C) | (Enable ? Req_In : 8'h00); on the same bit, set wins over clear.
REQ-014 SHALL implement a two-state FSM: IDLE (Valid=0) and SEND (Valid=1).
REQ-015 SHALL in IDLE, when P != 0, load Code_Out = priority-encode(P) per LOW_FIRST, set Valid=1, go to SEND on that edge.
REQ-016 SHALL give latency: Req_In[i] sampled at edge k -> Pending[i]=1 after edge k -> Valid=1 and Code_Out=i after edge k+1, with P previously 0.
REQ-017 SHALL in SEND with Ready=0 hold Code_Out and Valid unchanged; no pending bit changes the presented code.
REQ-018 SHALL on handshake, when R = P & ~C is nonzero, load Code_Out = priority-encode(R) and stay in SEND, giving back-to-back throughput of one code per cycle.
REQ-019 SHALL on handshake with R = 0 drive Valid=0 and go to IDLE; requests arriving that cycle are presented from IDLE on the following edge.
REQ-020 SHALL pulse Overflow=1 for one cycle after edge k when Enable=1 and Req_In[i]=1 and P[i]=1 and C[i]=0 for any i; the event is merged and not counted twice.
REQ-021 SHALL never assert Overflow for a bit whose set coincides with its handshake clear.
REQ-022 SHALL with Enable=0 ignore Req_In, produce no Overflow, and continue draining pending events through the handshake.
REQ-023 SHALL keep Code_Out at its last value while Valid=0; its value is don't-care for consumers.

Reset
REQ-024 SHALL on rst_n=0, without waiting for clk, force P=8'h00, Code_Out=3'b000, Valid=0, Overflow=0, FSM=IDLE.
REQ-025 SHALL discard pending events and any in-flight code when reset asserts mid-operation; no handshake is credited.
REQ-026 SHALL resume normal operation on the first rising edge after rst_n returns high.

Verification
REQ-027 SHALL verify single event: Enable=1, Req_In=8'h20 for one cycle, Ready=1 -> Pending=8'h20, next edge Valid=1 Code_Out=5, next edge Valid=0 Pending=8'h00.
REQ-028 SHALL verify ordering: Req_In=8'h91 one cycle, Ready=1, LOW_FIRST=1 -> Code_Out 0, 4, 7 on consecutive cycles then Valid=0; with LOW_FIRST=0 -> 7, 4, 0.
REQ-029 SHALL verify back-pressure: Req_In=8'h0C, Ready=0 for 5 cycles -> Valid=1 Code_Out=2 stable for all 5; Ready=1 -> 2 then 3.
REQ-030 SHALL verify overflow and collision: Pending=8'h02 with Ready=0, Req_In=8'h02 -> Overflow pulse, Pending stays 8'h02; a set coinciding with the handshake of code 1 -> no Overflow, Pending[1]=1, code 1 presented again.
REQ-031 SHALL verify Enable masking: Enable=0, Req_In=8'hFF -> Pending unchanged, no Overflow, existing events still drain.
REQ-032 SHALL verify async reset: rst_n low mid-SEND with Pending=8'hF0 -> Valid=0, Pending=8'h00 immediately, before the next clk edge.
